// File: rtl/seq_divider.sv
`timescale 1ns/1ps
// seq_divider: radix-2 restoring divider that resolves one quotient bit per
// clock. It supports signed and unsigned operands, a start/done handshake, and
// divide-by-zero and signed-overflow flags.
module seq_divider #(
  parameter int WIDTH     = 16,
  parameter bit SIGNED_EN = 1'b1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             signed_mode,
  input  logic [WIDTH-1:0] dividend,
  input  logic [WIDTH-1:0] divisor,
  output logic             ready,
  output logic             done,
  output logic [WIDTH-1:0] quotient,
  output logic [WIDTH-1:0] remainder,
  output logic             div_by_zero,
  output logic             overflow
);

  localparam int CW = $clog2(WIDTH + 1);
  localparam logic [WIDTH-1:0] MIN_VAL = {1'b1, {(WIDTH-1){1'b0}}};

  typedef enum logic [1:0] {IDLE, RUN, FINISH} state_t;

  state_t           state, state_nx;
  logic [CW-1:0]    count;
  logic [WIDTH:0]   prem;       // partial remainder
  logic [WIDTH-1:0] dvd_q;      // dividend magnitude, shifts into quotient
  logic [WIDTH-1:0] dsr_q;      // divisor magnitude
  logic [WIDTH-1:0] orig_dvd;   // raw dividend, returned on divide-by-zero
  logic             q_neg, r_neg, dz_q, ovf_q;

  logic             eff_signed, dsr_zero, ovf_in;
  logic [WIDTH-1:0] dvd_mag, dsr_mag;
  logic [WIDTH+1:0] shifted, diff;
  logic [WIDTH-1:0] q_final, r_final;

  assign ready = (state == IDLE);

  // Operand preparation: effective mode, magnitudes and special-case detection
  always_comb begin
    eff_signed = signed_mode & SIGNED_EN;
    dsr_zero   = (divisor == '0);
    dvd_mag    = (eff_signed && dividend[WIDTH-1]) ? -dividend : dividend;
    dsr_mag    = (eff_signed && divisor[WIDTH-1])  ? -divisor  : divisor;
    ovf_in     = eff_signed && (dividend == MIN_VAL) && (divisor == '1);
  end

  // One restoring step and the final sign correction
  always_comb begin
    shifted = {prem, dvd_q[WIDTH-1]};
    diff    = shifted - {2'b00, dsr_q};
    q_final = q_neg ? -dvd_q : dvd_q;
    r_final = r_neg ? -prem[WIDTH-1:0] : prem[WIDTH-1:0];
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nx;
  end

  // Next-state logic
  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (start) state_nx = dsr_zero ? FINISH : RUN;
      RUN:     if (count == CW'(1)) state_nx = FINISH;
      FINISH:  if (count == '0) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  // Datapath: operand capture, iteration and result registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count       <= '0;
      prem        <= '0;
      dvd_q       <= '0;
      dsr_q       <= '0;
      orig_dvd    <= '0;
      q_neg       <= 1'b0;
      r_neg       <= 1'b0;
      dz_q        <= 1'b0;
      ovf_q       <= 1'b0;
      done        <= 1'b0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
      overflow    <= 1'b0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            dvd_q       <= dvd_mag;
            dsr_q       <= dsr_mag;
            orig_dvd    <= dividend;
            prem        <= '0;
            q_neg       <= eff_signed & (dividend[WIDTH-1] ^ divisor[WIDTH-1]);
            r_neg       <= eff_signed & dividend[WIDTH-1];
            dz_q        <= dsr_zero;
            ovf_q       <= ovf_in;
            div_by_zero <= 1'b0;
            overflow    <= 1'b0;
            // divide-by-zero skips RUN but spends an extra FINISH cycle,
            // giving a fixed two-edge latency for that path
            count       <= dsr_zero ? CW'(1) : CW'(WIDTH);
          end
        end
        RUN: begin
          count <= count - CW'(1);
          if (!diff[WIDTH+1]) begin
            prem  <= diff[WIDTH:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b1};
          end else begin
            prem  <= shifted[WIDTH:0];
            dvd_q <= {dvd_q[WIDTH-2:0], 1'b0};
          end
        end
        FINISH: begin
          if (count != '0) begin
            count <= count - CW'(1);
          end else begin
            done        <= 1'b1;
            div_by_zero <= dz_q;
            overflow    <= ovf_q;
            quotient    <= dz_q ? '1 : q_final;
            remainder   <= dz_q ? orig_dvd : r_final;
          end
        end
        default: count <= '0;
      endcase
    end
  end

endmodule
